// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Front-panel LED controller. Two active-low push buttons are synchronized,
// debounced and turned into one-cycle press events. button_0 steps the blink
// rate and button_1 steps the display mode (OFF, BLINK, CHASE, COUNT). A
// prescaler generates the pattern tick at BASE_DIV << rate_idx clk cycles.
//
// Build option:
//   DEBOUNCE_EN  defined   : DEB_CYCLES consecutive differing synchronized
//                            samples are needed to accept a new button level.
//                undefined : no debounce counters; the accepted level follows
//                            the synchronizer output every cycle.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   button_0  in   1  rate button, active-low, asynchronous
//   button_1  in   1  mode button, active-low, asynchronous
//   led       out  N  registered LED drive, 1 = lit
//   mode      out  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 COUNT
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int N          = 3,
    parameter int DEB_CYCLES = 4,
    parameter int BASE_DIV   = 4,
    parameter int RATES      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         button_0,
    input  logic         button_1,
    output logic [N-1:0] led,
    output logic [1:0]   mode
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_COUNT = 2'd3;

    // Prescaler must hold the longest period minus one.
    localparam int CW = $clog2(BASE_DIV << (RATES - 1));
    localparam int RW = (RATES > 1) ? $clog2(RATES) : 1;

    localparam logic [CW:0]   BASE_W    = (CW + 1)'(BASE_DIV);
    localparam logic [RW-1:0] RATE_LAST = RW'(RATES - 1);

    // -------------------------------------------------------------------------
    // Button front end: synchronizer, optional debouncer, press detection.
    // Index 0 = rate button, index 1 = mode button.
    // -------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {button_1, button_0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic sync1_q;
            logic sync2_q;
            logic acc_q;
            logic acc_d;
            logic prev_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

`ifdef DEBOUNCE_EN
            localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

            logic [DW-1:0] cnt_q;
            logic [DW-1:0] cnt_d;

            // The counter only survives while every sample disagrees with the
            // accepted level; the DEB_CYCLES-th such sample commits the change.
            always_comb begin
                acc_d = acc_q;
                cnt_d = '0;
                if (sync2_q != acc_q) begin
                    if (cnt_q == DEB_LAST) begin
                        acc_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
`else
            always_comb begin
                acc_d = sync2_q;
            end
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q  <= 1'b1;
                    prev_q <= 1'b1;
                end else begin
                    acc_q  <= acc_d;
                    prev_q <= acc_q;
                end
            end

            // Falling accepted level only; releases are ignored.
            assign press[gi] = prev_q & ~acc_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Rate, prescaler, mode and pattern registers.
    // -------------------------------------------------------------------------
    logic [RW-1:0] rate_idx_q, rate_idx_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    mode_q, mode_d;
    logic [N-1:0]  led_q, led_d;

    logic [CW:0]   period;
    logic [CW-1:0] period_m1;
    logic          tick;
    logic          rate_press;
    logic          mode_press;

    assign rate_press = press[0];
    assign mode_press = press[1];

    assign period    = BASE_W << rate_idx_q;
    assign period_m1 = CW'(period - 1'b1);
    assign tick      = (presc_q == period_m1);

    always_comb begin
        rate_idx_d = rate_idx_q;
        if (rate_press) begin
            rate_idx_d = (rate_idx_q == RATE_LAST) ? '0 : rate_idx_q + 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (rate_press || mode_press || tick) begin
            presc_d = '0;
        end
    end

    // Two-bit increment wraps COUNT back to OFF on its own.
    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            mode_d = mode_q + 2'd1;
        end
    end

    // A mode change loads the new mode's initial pattern and wins over a tick
    // landing on the same edge.
    always_comb begin
        led_d = led_q;
        if (mode_press) begin
            case (mode_d)
                MODE_CHASE: led_d = N'(1);
                default:    led_d = '0;
            endcase
        end else if (tick) begin
            case (mode_q)
                MODE_OFF:   led_d = '0;
                MODE_BLINK: led_d = {N{~led_q[0]}};
                MODE_CHASE: led_d = {led_q[N-2:0], led_q[N-1]};
                MODE_COUNT: led_d = led_q + 1'b1;
                default:    led_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_idx_q <= '0;
            presc_q    <= '0;
            mode_q     <= MODE_BLINK;
            led_q      <= '0;
        end else begin
            rate_idx_q <= rate_idx_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed bench for led_sequencer with default parameters. Press latency and
// glitch behaviour follow the DEBOUNCE_EN build option. Each comparison prints
// one line.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int N     = 3;
    localparam int DEB   = 4;
    localparam int BASE  = 4;
    localparam int RATES = 4;

`ifdef DEBOUNCE_EN
    localparam int LAT       = 3 + DEB;  // edges from first low sample to mode/rate update
    localparam bit GLITCH_OK = 1'b0;     // 2-cycle pulse is rejected
`else
    localparam int LAT       = 4;
    localparam bit GLITCH_OK = 1'b1;     // 2-cycle pulse counts as a press
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         button_0 = 1'b1;
    logic         button_1 = 1'b1;
    logic [N-1:0] led;
    logic [1:0]   mode;

    int checks   = 0;
    int failures = 0;
    int exp_rate = 0;
    int per      = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .N          (N),
        .DEB_CYCLES (DEB),
        .BASE_DIV   (BASE),
        .RATES      (RATES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button_0 (button_0),
        .button_1 (button_1),
        .led      (led),
        .mode     (mode)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until led changes; -1 if it does not change within limit.
    task automatic wait_led_change(input int limit, output int cycles);
        logic [N-1:0] prev;
        prev   = led;
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (led !== prev) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        // Reset state and first BLINK ticks.
        rst = 1'b1;
        step(2);
        check_eq("rst_led", 32'(led), 0);
        check_eq("rst_mode", 32'(mode), 1);
        rst = 1'b0;
        step(3);
        check_eq("blink_pre_tick", 32'(led), 0);
        step(1);
        check_eq("blink_tick1", 32'(led), 7);
        step(3);
        check_eq("blink_hold", 32'(led), 7);
        step(1);
        check_eq("blink_tick2", 32'(led), 0);

        // Held mode button: one event, BLINK -> CHASE.
        button_1 = 1'b0;
        step(LAT - 1);
        check_eq("mode_lat_pre", 32'(mode), 1);
        step(1);
        check_eq("mode_lat", 32'(mode), 2);
        check_eq("chase_init", 32'(led), 1);
        step(4);
        check_eq("chase_1", 32'(led), 2);
        step(4);
        check_eq("chase_2", 32'(led), 4);
        step(4);
        check_eq("chase_wrap", 32'(led), 1);
        button_1 = 1'b1;
        step(10);
        check_eq("chase_after_rel", 32'(led), 4);
        check_eq("mode_held_once", 32'(mode), 2);

        // Short rate-button glitch.
        button_0 = 1'b0;
        step(2);
        button_0 = 1'b1;
        step(10);
        if (GLITCH_OK) exp_rate = (exp_rate + 1) % RATES;
        wait_led_change(80, cyc);
        wait_led_change(80, cyc);
        check_eq("glitch_period", 32'(cyc), 32'(BASE << exp_rate));

        // Four rate presses; the last one wraps.
        for (int k = 0; k < 4; k++) begin
            button_0 = 1'b0;
            step(DEB + 6);
            button_0 = 1'b1;
            step(DEB + 6);
            exp_rate = (exp_rate + 1) % RATES;
            wait_led_change(80, cyc);
            wait_led_change(80, cyc);
            check_eq($sformatf("rate_period_%0d", k), 32'(cyc), 32'(BASE << exp_rate));
        end

        // CHASE -> COUNT and a full count wrap.
        per = BASE << exp_rate;
        button_1 = 1'b0;
        step(LAT);
        check_eq("count_mode", 32'(mode), 3);
        check_eq("count_init", 32'(led), 0);
        for (int i = 1; i <= 8; i++) begin
            step(per);
            check_eq($sformatf("count_%0d", i), 32'(led), 32'(i % 8));
        end
        button_1 = 1'b1;
        step(10);

        // Both buttons in the same cycle: COUNT -> OFF and rate steps.
        button_0 = 1'b0;
        button_1 = 1'b0;
        step(LAT);
        check_eq("both_mode", 32'(mode), 0);
        check_eq("both_led", 32'(led), 0);
        exp_rate = (exp_rate + 1) % RATES;
        per = BASE << exp_rate;
        button_0 = 1'b1;
        button_1 = 1'b1;
        step(40);
        check_eq("off_ignores_tick", 32'(led), 0);

        // OFF -> BLINK, first tick shows the new rate.
        button_1 = 1'b0;
        step(LAT);
        check_eq("blink_again_mode", 32'(mode), 1);
        check_eq("blink_again_led", 32'(led), 0);
        step(per - 1);
        check_eq("blink_newrate_pre", 32'(led), 0);
        step(1);
        check_eq("blink_newrate_tick", 32'(led), 7);
        button_1 = 1'b1;
        step(10);

        // BLINK -> CHASE, then reset with led = 100.
        button_1 = 1'b0;
        step(LAT);
        check_eq("chase2_mode", 32'(mode), 2);
        check_eq("chase2_init", 32'(led), 1);
        step(per);
        check_eq("chase2_1", 32'(led), 2);
        step(per);
        check_eq("chase2_2", 32'(led), 4);
        rst = 1'b1;
        button_1 = 1'b1;
        step(1);
        check_eq("midrst_led", 32'(led), 0);
        check_eq("midrst_mode", 32'(mode), 1);
        rst = 1'b0;
        step(BASE - 1);
        check_eq("postrst_pre", 32'(led), 0);
        step(1);
        check_eq("postrst_tick", 32'(led), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Front-panel LED controller for the blink design. It debounces the two active-low push buttons and produces an N-bit LED pattern. button_0 steps the blink rate and button_1 steps the display mode. It sits between the board button pins and the LED pins, and it owns all pattern sequencing and rate scheduling.

## Interface
Clock is clk; reset is rst, synchronous and active-high.

Parameters:
- N, 3: number of LEDs (≥2).
- DEB_CYCLES, 4: number of consecutive stable synchronized samples needed to accept a button level change (≥1).
- BASE_DIV, 4: tick period in clk cycles at rate index 0 (≥2).
- RATES, 4: number of rate steps. The period is BASE_DIV << rate_idx.

Ports:
- clk, in, 1: system clock; all state is updated on its rising edge.
- rst, in, 1: synchronous active-high reset.
- button_0, in, 1: rate button, active-low, asynchronous to clk.
- button_1, in, 1: mode button, active-low, asynchronous to clk.
- led, out, N: registered LED drive; 1 means lit.
- mode, out, 2: current mode (0 OFF, 1 BLINK, 2 CHASE, 3 COUNT).

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer. Both flops reset to 1 (released).
- **Debouncer:** per button, an accepted-level register (reset 1) and a counter (reset 0).
  - While the synchronizer output differs from the accepted level, the counter increments.
  - On the DEB_CYCLES-th consecutive differing sample, the accepted level is updated and the counter clears.
  - Any sample equal to the accepted level clears the counter.
- **Press event:** a one-cycle pulse, defined as previous accepted level = 1 and current accepted level = 0. Releases generate no event.
- **Rate:** rate_idx resets to 0. Each press of button_0 increments it, wrapping from RATES-1 to 0.
- **Prescaler:** the count runs 0..period-1 and resets to 0. tick = (count == period-1), after which the count returns to 0. A rate change clears the count.
- **Mode FSM:** resets to BLINK. Each press of button_1 advances OFF→BLINK→CHASE→COUNT→OFF.
  - A mode change clears the prescaler and loads the new mode's initial pattern.
- **Patterns** (the LED register updates only on tick or on a mode change):
  - OFF: led = 0. Ticks are ignored.
  - BLINK: all bits equal a phase bit. The initial phase is 0; the phase toggles on every tick.
  - CHASE: one-hot, initially bit 0. It rotates left on each tick, wrapping from bit N-1 to bit 0.
  - COUNT: N-bit binary value, initially 0. It increments on each tick, wrapping from 2^N-1 to 0.
- **Simultaneous presses** in the same cycle: both are applied. The rate steps, the mode advances, the prescaler clears, and the new mode's initial pattern loads.
- **Reset:** rst has priority over all events. It takes effect mid-pattern and mid-debounce.

## Timing
- **Reset values:** led = 0, mode = 1, rate_idx = 0, prescaler = 0, synchronizers and accepted levels = 1, debounce counters = 0.
- **First tick after rst deasserts:** occurs on the BASE_DIV-th rising edge. The LED register updates on that same edge.
- **Steady-state tick period:** exactly BASE_DIV << rate_idx clk cycles.
- **Press latency:** count edges from edge 1, the first edge that samples the button low.
  - The accepted level falls on edge 2+DEB_CYCLES.
  - mode or rate_idx updates on edge 3+DEB_CYCLES; led updates on that same edge.
- **Glitch rejection:** a low pulse seen for fewer than DEB_CYCLES consecutive synchronized samples produces no event.
- A held button produces exactly one event.

## Configuration
- **DEBOUNCE_EN defined:** the debouncer operates as described above.
- **DEBOUNCE_EN undefined:**
  - The debounce counters are removed.
  - The accepted level loads the synchronizer output every cycle, equivalent to DEB_CYCLES = 1.
  - Press latency becomes edge 4.
  - All other behaviour is unchanged.

## Test plan
Defaults N=3, DEB_CYCLES=4, BASE_DIV=4, RATES=4; DEBOUNCE_EN defined unless stated.
- Hold rst high 2 cycles, then release → led=000 and mode=1; led=111 on edge 4 after release, then toggles every 4 cycles.
- Hold button_1 low 10 cycles → mode=2 on edge 7 with led=001, then 010, 100, 001 every 4 cycles; release causes no further change.
- Pulse button_0 low for 2 cycles → no rate change, period stays 4. Repeat with DEBOUNCE_EN undefined → rate_idx=1, period 8.
- Three separate button_0 presses → periods 8, 16, 32; a fourth press wraps to period 4.
- Advance to COUNT mode → led steps 000→001→…→111→000 at the tick period. Press both buttons in the same cycle → mode=OFF, led=000, and rate advances.
- Assert rst mid-CHASE with led=100 → on the next edge led=000, mode=1, rate_idx=0, and the first tick occurs BASE_DIV cycles after release.
